// File: rtl/product_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module   : product_accumulator_if
//  Purpose  : Stream interface between the multiplier-side producer, the
//             product accumulator and the downstream result consumer.
//  Signals  : in_valid/in_ready/in_product/in_last  - term stream
//             out_valid/out_ready/out_sum/out_count/out_ovf - frame result
//  Modports : master - producer/consumer side (testbench or upstream logic)
//             slave  - the accumulator
//  Revision : 1.0 - initial release
// ============================================================================
interface product_accumulator_if #(
   parameter int PROD_W    = 8,
   parameter int ACC_W     = 16,
   parameter int MAX_TERMS = 16
);
   localparam int CNT_W = $clog2(MAX_TERMS + 1);

   logic                in_valid;
   logic                in_ready;
   logic [PROD_W-1:0]   in_product;
   logic                in_last;
   logic                out_valid;
   logic                out_ready;
   logic [ACC_W-1:0]    out_sum;
   logic [CNT_W-1:0]    out_count;
   logic                out_ovf;

   modport master (
      output in_valid, in_product, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_product, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_ovf
   );
endinterface
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : product_accumulator
//  Purpose  : Signed streaming accumulator for the multiplier product stream.
//             Sums a frame of sign-extended products and hands the total,
//             term count and sticky overflow flag downstream via valid/ready.
//             A frame closes on in_last or when MAX_TERMS terms are accepted.
//  Ports    : clk            - rising-edge clock
//             rst            - synchronous active-high reset
//             bus (slave)    - term stream in, frame result out
//  Options  : PRODUCT_ACC_SAT_EN - when defined every add saturates to the
//             signed ACC_W range instead of wrapping; out_ovf is identical.
//  Revision : 1.0 - initial release
// ============================================================================
module product_accumulator #(
   parameter int PROD_W    = 8,
   parameter int ACC_W     = 16,
   parameter int MAX_TERMS = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   product_accumulator_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_TERMS + 1);

   localparam logic [0:0] S_ACCUM = 1'b0;
   localparam logic [0:0] S_DONE  = 1'b1;

   logic [0:0]        r_state;
   logic [0:0]        w_state_next;

   logic [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf;
   logic [ACC_W-1:0]  r_out_sum;
   logic [CNT_W-1:0]  r_out_cnt;
   logic              r_out_ovf;

   logic              w_accept;
   logic              w_handoff;
   logic              w_close;
   logic [ACC_W-1:0]  w_ext;
   logic [ACC_W-1:0]  w_sum;
   logic              w_add_ovf;
   logic [ACC_W-1:0]  w_acc_next;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_ovf_next;

   // ---------------------------------------------------------------- datapath
   assign w_accept   = bus.in_valid && (r_state == S_ACCUM);
   assign w_handoff  = bus.out_ready && (r_state == S_DONE);

   // Size cast of a signed operand sign-extends to the accumulator width.
   assign w_ext      = ACC_W'($signed(bus.in_product));
   assign w_sum      = r_acc + w_ext;

   // Overflow only possible when both operands share a sign and the
   // result's sign flips away from it.
   assign w_add_ovf  = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                       (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef PRODUCT_ACC_SAT_EN
   // On overflow the operand sign tells the direction of the clamp.
   assign w_acc_next = !w_add_ovf     ? w_sum :
                       r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                        {1'b0, {(ACC_W-1){1'b1}}};
`else
   assign w_acc_next = w_sum;
`endif

   assign w_cnt_next = r_cnt + 1'b1;
   assign w_ovf_next = r_ovf | w_add_ovf;
   assign w_close    = bus.in_last || (w_cnt_next == CNT_W'(MAX_TERMS));

   // ---------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_ACCUM;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------- next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_ACCUM: if (w_accept && w_close) w_state_next = S_DONE;
         S_DONE:  if (bus.out_ready)       w_state_next = S_ACCUM;
         default: w_state_next = S_ACCUM;
      endcase
   end

   // ---------------------------------------------------------- outputs
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (r_state)
         S_ACCUM: bus.in_ready  = 1'b1;
         S_DONE:  bus.out_valid = 1'b1;
         default: bus.in_ready  = 1'b0;
      endcase
   end

   // ---------------------------------------------------------- frame state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_out_sum <= '0;
         r_out_cnt <= '0;
         r_out_ovf <= 1'b0;
      end else if (w_accept) begin
         r_acc <= w_acc_next;
         r_cnt <= w_cnt_next;
         r_ovf <= w_ovf_next;
         if (w_close) begin
            r_out_sum <= w_acc_next;
            r_out_cnt <= w_cnt_next;
            r_out_ovf <= w_ovf_next;
         end
      end else if (w_handoff) begin
         // Result registers keep the last frame; only the running frame clears.
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end
   end

   assign bus.out_sum   = r_out_sum;
   assign bus.out_count = r_out_cnt;
   assign bus.out_ovf   = r_out_ovf;

endmodule
`default_nettype wire
